// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between two writeback
//   requesters (for example ALU writeback on req0 and load writeback on req1).
//   Each requester uses a valid/ready handshake. The winning write is
//   registered onto the port, so it appears there one cycle after the
//   handshake. Cycles where both requesters compete are counted.
//
// Ports
//   clock                 system clock, all state updates on the rising edge
//   resetN                synchronous reset, active low
//   hold                  1 = freeze the port, no grants this cycle
//   req0Valid / req1Valid requester has a write pending
//   req0Ready / req1Ready write accepted this cycle (combinational)
//   req0Reg / req1Reg     destination register index
//   req0Data / req1Data   write data
//   regWrite              registered write enable to the register file
//   writeRegister         registered register index
//   writeData             registered write data
//   conflictCount         saturating count of contention cycles
//
// Parameters
//   DATA_W     width of the write data
//   ADDR_W     width of the register index
//   FIXED_PRI  0 = round-robin between the requesters, 1 = req0 always wins

module regfile_write_arbiter #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              hold,
  input  logic              req0Valid,
  output logic              req0Ready,
  input  logic [ADDR_W-1:0] req0Reg,
  input  logic [DATA_W-1:0] req0Data,
  input  logic              req1Valid,
  output logic              req1Ready,
  input  logic [ADDR_W-1:0] req1Reg,
  input  logic [DATA_W-1:0] req1Data,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeRegister,
  output logic [DATA_W-1:0] writeData,
  output logic [7:0]        conflictCount
);

  logic              grant0;
  logic              grant1;
  logic              transfer;
  logic              contention;

  logic              rr_ptr_q;
  logic              rr_ptr_d;
  logic              reg_write_q;
  logic              reg_write_d;
  logic [ADDR_W-1:0] write_register_q;
  logic [ADDR_W-1:0] write_register_d;
  logic [DATA_W-1:0] write_data_q;
  logic [DATA_W-1:0] write_data_d;
  logic [7:0]        conflict_count_q;
  logic [7:0]        conflict_count_d;

  // Grant logic. Reset and hold both mask every grant, so a Ready can never
  // rise while the block is in reset or frozen. When both requesters are
  // valid, the round-robin pointer names the favoured one (0 = req0).
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (resetN && !hold) begin
      if (req0Valid && req1Valid) begin
        if (FIXED_PRI || !rr_ptr_q) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else begin
        grant0 = req0Valid;
        grant1 = req1Valid;
      end
    end
  end

  assign transfer   = grant0 | grant1;
  assign contention = resetN & ~hold & req0Valid & req1Valid;

  // Next-state logic. The output stage captures the winner and otherwise
  // keeps its index and data, dropping only the enable. After a transfer the
  // pointer favours the requester that lost, which is the value of grant0.
  always_comb begin
    reg_write_d      = transfer;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    rr_ptr_d         = rr_ptr_q;
    conflict_count_d = conflict_count_q;

    if (grant0) begin
      write_register_d = req0Reg;
      write_data_d     = req0Data;
    end else if (grant1) begin
      write_register_d = req1Reg;
      write_data_d     = req1Data;
    end

    if (!FIXED_PRI && transfer) begin
      rr_ptr_d = grant0;
    end

    if (contention && (conflict_count_q != 8'hFF)) begin
      conflict_count_d = conflict_count_q + 8'd1;
    end
  end

  // State registers with synchronous active-low reset. Reset also cancels
  // any write sitting in the output stage.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      rr_ptr_q         <= 1'b0;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      conflict_count_q <= 8'd0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      conflict_count_q <= conflict_count_d;
    end
  end

  assign req0Ready     = grant0;
  assign req1Ready     = grant1;
  assign regWrite      = reg_write_q;
  assign writeRegister = write_register_q;
  assign writeData     = write_data_q;
  assign conflictCount = conflict_count_q;

endmodule
